// File: rtl/game_countdown.sv
// Round timer for the whack-a-mole game: counts a round down in BCD from START_SECONDS
// on 1 Hz ticks, flags the closing seconds and reports round end.
module game_countdown #(
    parameter int unsigned START_SECONDS = 60,
    parameter int unsigned WARN_SECONDS  = 10
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       hold,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       time_up,
    output logic       game_over,
    output logic       warning
);

    localparam logic [3:0] StartTens = 4'(START_SECONDS / 10);
    localparam logic [3:0] StartOnes = 4'(START_SECONDS % 10);
    localparam logic [6:0] WarnLimit = 7'(WARN_SECONDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       game_over_q;
    logic [6:0] remaining;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= StIdle;
            tens_q      <= StartTens;
            ones_q      <= StartOnes;
            game_over_q <= 1'b0;
        end else begin
            game_over_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    // A start arriving with a tick wins; the tick is dropped.
                    if (start) begin
                        state_q <= StRun;
                        tens_q  <= StartTens;
                        ones_q  <= StartOnes;
                    end
                end
                StRun: begin
                    if (tick_1hz && !hold) begin
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            ones_q      <= 4'd0;
                            state_q     <= StDone;
                            game_over_q <= 1'b1;
                        end else if (ones_q != 4'd0) begin
                            ones_q <= ones_q - 4'd1;
                        end else begin
                            ones_q <= 4'd9;
                            tens_q <= tens_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tens_q  <= StartTens;
                    ones_q  <= StartOnes;
                end
            endcase
        end
    end

    always_comb begin
        remaining = 7'(tens_q) * 7'd10 + 7'(ones_q);
        tens      = tens_q;
        ones      = ones_q;
        running   = (state_q == StRun);
        time_up   = (state_q == StDone);
        game_over = game_over_q;
        warning   = running && (remaining != 7'd0) && (remaining <= WarnLimit);
    end

endmodule

// File: doc/game_countdown.md
# game_countdown

Whack-a-mole round timer that sits directly downstream of the 1 Hz tick generator. Consumes the single-cycle once-per-second tick, counts a round down from a parameterised number of seconds, and presents the remaining time as two BCD digits for the seven-segment display driver. Flags the last seconds of a round and signals round end to the game controller.

## Interface
- START_SECONDS, 60: round length in seconds; legal range 1..99.
- WARN_SECONDS, 10: warning asserted while remaining time is 1..WARN_SECONDS; legal range 0..99.

- clk_in  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-cycle pulse per second from the tick generator; synchronous to clk_in.
- start  input  1  one-cycle pulse; begins a new round.
- hold  input  1  level; while high, ticks are ignored and the count freezes.
- tens  output  4  BCD tens digit of remaining seconds.
- ones  output  4  BCD ones digit of remaining seconds.
- running  output  1  high in RUN state.
- time_up  output  1  level; high in DONE state.
- game_over  output  1  one-cycle pulse on entry to DONE.
- warning  output  1  running && remaining is in 1..WARN_SECONDS.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: digits hold START_SECONDS in BCD. start -> RUN, with digits reloaded to START_SECONDS.
- RUN:
  - tick_1hz && !hold -> decrement the BCD count.
  - Decrement rule: if ones != 0, then ones-1; else ones=9, tens-1.
  - Decrement from 01 -> digits 00, state DONE, game_over=1 for that one cycle.
- RUN, start: ignored; there is no mid-round restart.
- RUN, hold: freezes the count and does not change state. running stays high.
- DONE:
  - Digits hold 00 and time_up=1.
  - Ticks are ignored.
  - start -> RUN with digits reloaded to START_SECONDS, and time_up clears.
- Count is never decremented below 00. tens and ones are always valid BCD (0..9).
- warning is combinational from registered state. It is never high in IDLE or DONE, and never high at 00.
- Simultaneous events:
  - start and tick_1hz in the same cycle, in IDLE or DONE: start wins; the tick is discarded and the count is not decremented.
  - tick_1hz and hold in the same cycle: the tick is discarded.
- Reset in any state, including mid-round: next cycle is IDLE, with tens/ones = START_SECONDS in BCD, running=0, time_up=0, game_over=0, warning=0. Reset has priority over start and tick.

## Timing
- All state, digits and game_over are registered on posedge clk_in.
- Tick sampled high at edge N -> new digits visible after edge N (one-cycle latency).
- start sampled at edge N -> running=1 after edge N. The first decrement happens on the first non-held tick after that edge, so the first displayed second lasts up to one full tick period.
- On the edge that produces 00: running falls, time_up rises and game_over pulses, all in the same cycle. game_over clears on the following edge regardless of inputs.
- No handshake to the tick generator. The block never stalls it and never counts a tick more than once.

## Test plan
- Reset then idle, START_SECONDS=60: tens=6, ones=0, running=0, time_up=0, warning=0. 200 ticks with no start leave digits unchanged.
- start, then 1 tick -> 59. After 10 ticks -> 50. The 00->09 borrow occurs correctly at 50->49. After 60 ticks -> 00, game_over is high exactly one cycle, then time_up=1 and running=0.
- START_SECONDS=12, WARN_SECONDS=10: after start, warning=0 at 12 and 11, and warning=1 from 10 down to 01. At 00, warning=0.
- hold high across 5 ticks at 37 -> digits stay 37 and running stays 1. Release hold, then 1 tick -> 36.
- start coincident with tick in IDLE -> digits = START_SECONDS, running=1. Later start pulses during RUN leave digits unchanged.
- reset asserted at 23 mid-round -> next cycle shows IDLE with digits 60. start from DONE reloads 60 with time_up=0 and running=1.
